chip_sr_latch_tester: RTL
=========================

Name: chip_sr_latch_tester

Overview:
- Parametrised tester for quad S-R latch chips of the 74279 family: any channel count, and any mix of single-S and dual-S channels.
- Drives active-low S/R stimulus to every channel in parallel through an 8-vector sequence, samples Q after a settle window, and reports pass/fail.
- Adds per-channel fail flags, first-failing-vector capture and optional stop-on-fail.
- Sits between the checker top-level FSM (Run/Done/RSLT handshake) and the socket pin mux.

Parameters:
- NUM_CH, 4, number of latch channels under test (1..8).
- DUAL_S_MASK, 4'b0101, bit i = 1 means channel i has a second set input S2.
- SETTLE_CYCLES, 4, clocks between applying a vector and sampling Q (>=1).
- STOP_ON_FAIL, 0, 1 = end the run at the first failing vector.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  start request, level; a run starts on the rising edge of Run.
- S1_n  out  NUM_CH  active-low set input 1 per channel.
- S2_n  out  NUM_CH  active-low set input 2; bits for channels without S2 are tied to 1.
- R_n  out  NUM_CH  active-low reset per channel.
- Q  in  NUM_CH  latch outputs from the socket.
- Done  out  1  high while in DONE.
- RSLT  out  1  1 = pass; valid only in DONE with DISP_RSLT=1, else 0.
- DISP_RSLT  in  1  result display enable.
- FAIL_CH  out  NUM_CH  sticky per-channel mismatch flags.
- FAIL_VEC  out  3  index of the first failing vector; 3'd7 if none.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; S1_n, S2_n and R_n all 1s.
  - Done=0, RSLT=0, FAIL_CH=0, FAIL_VEC=7.
  - The vector index, settle counter, first-fail flag and Run edge register are cleared.
  - Asserting Reset mid-run aborts immediately, with no Done pulse.
- States: IDLE -> APPLY -> SETTLE -> CHECK -> (APPLY | DONE); DONE -> IDLE.
- IDLE:
  - Pins idle at all 1s.
  - A Run rising edge (registered Run was 0, now 1) clears FAIL_CH and FAIL_VEC, sets vec=0 and goes to APPLY.
- APPLY (1 cycle): drives the vector-vec pattern on all channels and loads settle count = SETTLE_CYCLES.
- SETTLE: decrements each cycle and goes to CHECK when the count reaches 1. Pins hold.
- CHECK (1 cycle):
  - Compares Q against the expected value per channel.
  - Mismatching bits OR into FAIL_CH.
  - On the first mismatch of the run, FAIL_VEC=vec.
  - If vec==7, or (STOP_ON_FAIL and a mismatch occurred this cycle), go to DONE. Otherwise vec++ and go to APPLY.
- Per-vector time: SETTLE_CYCLES+2 clocks. A full run takes 8*(SETTLE_CYCLES+2) clocks from APPLY of V0 to entry into DONE.
- Vectors (S1_n, S2_n, R_n -> expected Q). "D" = dual-S channel, "S" = single-S channel:
  - V0: 1, 1, 0 -> 0.
  - V1: 1, 1, 1 -> 0 (hold).
  - V2: 0, 1, 1 -> 1.
  - V3: 1, 1, 1 -> 1 (hold).
  - V4: 1, 1, 0 -> 0.
  - V5: 1, 0, 1 -> D:1, S:0. S channels see S2_n=1.
  - V6: 1, 1, 1 -> D:1, S:0 (hold).
  - V7: 0, 0, 0 -> 1 (set dominates; S channels drive S1_n=0 only).
- S2_n bits of S channels are always 1, in every state.
- DONE:
  - Done=1; pins return to all 1s.
  - FAIL_CH and FAIL_VEC hold their values.
  - RSLT = DISP_RSLT & (FAIL_CH==0).
  - Run=0 returns to IDLE next clock (Done falls). While Run stays 1, remain in DONE. No restart without a new rising edge.
- Run falling mid-sequence is ignored; the sequence completes.
- FAIL_VEC is not updated again once set, even if later vectors also fail.

Test Plan:
- Ideal 74279 model, NUM_CH=4, DUAL_S_MASK=0101, SETTLE=4, DISP_RSLT=1, pulse Run -> Done after 48 clocks, RSLT=1, FAIL_CH=0000, FAIL_VEC=7.
- Channel 2 Q stuck-at-0 -> FAIL_CH=0100, FAIL_VEC=2, RSLT=0, Done after 48 clocks.
- Channel 0 S2 pin open (ignored by model) -> FAIL_CH=0001, FAIL_VEC=5. Single channels 1 and 3 show S2_n=1 throughout.
- STOP_ON_FAIL=1, channel 1 Q stuck-at-1 -> DONE entered after V0 CHECK (6 clocks), FAIL_VEC=0, FAIL_CH=0010.
- Pass run with DISP_RSLT=0 -> RSLT=0. Raising DISP_RSLT -> RSLT=1 next cycle. Holding Run=1 keeps Done=1. Dropping Run -> IDLE, Done=0.
- Reset asserted at vector 3 SETTLE -> all pins 1 and Done=0 immediately. A new Run edge restarts from V0 with flags cleared.

Source files
------------

// File: rtl/chip_sr_latch_tester.sv
// chip_sr_latch_tester: drives an 8-vector S/R sequence into 74279-style latch channels and checks Q.
// Channels flagged in DUAL_S_MASK also receive S2 stimulus; others hold S2_n high.
module chip_sr_latch_tester #(
  parameter int         NUM_CH        = 4,
  parameter logic [7:0] DUAL_S_MASK   = 8'b0000_0101,
  parameter int         SETTLE_CYCLES = 4,
  parameter bit         STOP_ON_FAIL  = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  output logic [NUM_CH-1:0] S1_n,
  output logic [NUM_CH-1:0] S2_n,
  output logic [NUM_CH-1:0] R_n,
  input  logic [NUM_CH-1:0] Q,
  output logic              Done,
  output logic              RSLT,
  input  logic              DISP_RSLT,
  output logic [NUM_CH-1:0] FAIL_CH,
  output logic [2:0]        FAIL_VEC
);
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [NUM_CH-1:0] DM = DUAL_S_MASK[NUM_CH-1:0];
  // Per-vector row {S1_n, S2_n(dual), R_n, expected dual Q, expected single Q}, V7 in the top slice.
  localparam logic [39:0] VT = {5'b00011, 5'b11110, 5'b10110, 5'b11000,
                                5'b11111, 5'b01111, 5'b11100, 5'b11000};
  state_t            r_state, w_next;
  logic [2:0]        r_vec;
  logic [CW-1:0]     r_cnt;
  logic              r_ff;
  logic              r_run;
  logic [NUM_CH-1:0] r_fail_ch;
  logic [2:0]        r_fail_vec;
  logic              w_rise;
  logic              w_active;
  logic [4:0]        w_row;
  logic [NUM_CH-1:0] w_exp;
  logic [NUM_CH-1:0] w_mis;
  assign w_rise   = Run & ~r_run;
  assign w_active = (r_state == APPLY) || (r_state == SETTLE) || (r_state == CHECK);
  assign w_row    = VT[r_vec*5 +: 5];
  assign w_exp    = ({NUM_CH{w_row[1]}} & DM) | ({NUM_CH{w_row[0]}} & ~DM);
  assign w_mis    = (r_state == CHECK) ? (Q ^ w_exp) : '0;
  assign FAIL_CH  = r_fail_ch;
  assign FAIL_VEC = r_fail_vec;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_rise ? APPLY : IDLE;
      APPLY:   w_next = SETTLE;
      SETTLE:  w_next = (r_cnt == CW'(1)) ? CHECK : SETTLE;
      CHECK:   w_next = ((r_vec == 3'd7) || (STOP_ON_FAIL && (|w_mis))) ? DONE : APPLY;
      DONE:    w_next = Run ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    S1_n = w_active ? {NUM_CH{w_row[4]}} : '1;
    S2_n = w_active ? ({NUM_CH{w_row[3]}} | ~DM) : '1;
    R_n  = w_active ? {NUM_CH{w_row[2]}} : '1;
    Done = (r_state == DONE);
    RSLT = (r_state == DONE) & DISP_RSLT & ~(|r_fail_ch);
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_run      <= 1'b0;
      r_vec      <= 3'd0;
      r_cnt      <= '0;
      r_ff       <= 1'b0;
      r_fail_ch  <= '0;
      r_fail_vec <= 3'd7;
    end else begin
      r_run <= Run;
      if (r_state == IDLE && w_rise) begin
        r_vec      <= 3'd0;
        r_ff       <= 1'b0;
        r_fail_ch  <= '0;
        r_fail_vec <= 3'd7;
      end
      if (r_state == APPLY) r_cnt <= CW'(SETTLE_CYCLES);
      if (r_state == SETTLE) r_cnt <= r_cnt - 1'b1;
      if (r_state == CHECK) begin
        r_fail_ch <= r_fail_ch | w_mis;
        if ((|w_mis) && !r_ff) begin
          r_ff       <= 1'b1;
          r_fail_vec <= r_vec;
        end
        if (w_next == APPLY) r_vec <= r_vec + 3'd1;
      end
    end
  end
endmodule
